// File: rtl/wave_playback_if.sv
// Wave playback channel bus: control inputs from the sound block, sample/status to the mixer.
interface wave_playback_if #(
    parameter int SAMPLE_W     = 4,
    parameter int BANK_SAMPLES = 32,
    parameter int NUM_BANKS    = 2,
    parameter int LEN_W        = 8
);
    localparam int RAM_W  = NUM_BANKS * BANK_SAMPLES * SAMPLE_W;
    localparam int POS_W  = $clog2(BANK_SAMPLES);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic [RAM_W-1:0]    wave_ram;
    logic [BANK_W-1:0]   bank_select;
    logic                dimension;
    logic                dac_enable;
    logic                trigger;
    logic [1:0]          volume_code;
    logic                force_75;
    logic                length_enable;
    logic [LEN_W-1:0]    length_value;
    logic                length_tick;
    logic [SAMPLE_W-1:0] wave_out;
    logic                active;
    logic [POS_W-1:0]    position;
    logic [BANK_W-1:0]   bank_playing;

    modport master (
        output wave_ram, bank_select, dimension, dac_enable, trigger,
        output volume_code, force_75, length_enable, length_value, length_tick,
        input  wave_out, active, position, bank_playing
    );

    modport slave (
        input  wave_ram, bank_select, dimension, dac_enable, trigger,
        input  volume_code, force_75, length_enable, length_value, length_tick,
        output wave_out, active, position, bank_playing
    );
endinterface

// File: rtl/wave_playback_channel.sv
// Banked 4-bit wave-RAM playback channel with length counter and volume scaling.
// Optional WAVE_FORCE75_EN: force_75 selects a 75% volume override.
module wave_playback_channel #(
    parameter int SAMPLE_W     = 4,
    parameter int BANK_SAMPLES = 32,
    parameter int NUM_BANKS    = 2,
    parameter int LEN_W        = 8
) (
    input  logic            frequency_timer_clock,
    input  logic            reset,
    wave_playback_if.slave  bus
);
    localparam int RAM_W  = NUM_BANKS * BANK_SAMPLES * SAMPLE_W;
    localparam int POS_W  = $clog2(BANK_SAMPLES);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int OFF_W  = $clog2(RAM_W);
    localparam int CNT_W  = LEN_W + 1;

    typedef enum logic {
        S_IDLE,
        S_PLAYING
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [POS_W-1:0]    r_pos;
    logic [BANK_W-1:0]   r_bank;
    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_wave;

    logic                w_trig;
    logic                w_dec;
    logic                w_run;
    logic [OFF_W-1:0]    w_off;
    logic [SAMPLE_W-1:0] w_sample;
    logic [SAMPLE_W-1:0] w_scaled;
    logic [CNT_W-1:0]    w_reload;

    // Even samples live in the high nibble of each byte.
    assign w_off = OFF_W'(r_bank) * OFF_W'(BANK_SAMPLES * SAMPLE_W)
                 + OFF_W'(r_pos >> 1) * OFF_W'(2 * SAMPLE_W)
                 + (r_pos[0] ? OFF_W'(0) : OFF_W'(SAMPLE_W));

    assign w_sample = bus.wave_ram[w_off +: SAMPLE_W];
    assign w_reload = {1'b1, {LEN_W{1'b0}}} - CNT_W'(bus.length_value);

`ifdef WAVE_FORCE75_EN
    logic [SAMPLE_W+1:0] w_prod;
    assign w_prod = (SAMPLE_W+2)'(w_sample) * (SAMPLE_W+2)'(3);
`else
    logic w_unused_force75;
    assign w_unused_force75 = bus.force_75;
`endif

    always_comb begin
        w_scaled = '0;
        case (bus.volume_code)
            2'b01:   w_scaled = w_sample;
            2'b10:   w_scaled = w_sample >> 1;
            2'b11:   w_scaled = w_sample >> 2;
            default: w_scaled = '0;
        endcase
`ifdef WAVE_FORCE75_EN
        if (bus.force_75)
            w_scaled = w_prod[SAMPLE_W+1:2];
`endif
    end

    always_ff @(posedge frequency_timer_clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // dac_enable beats trigger; trigger beats a same-edge length tick.
    always_comb begin
        w_trig = bus.dac_enable & bus.trigger;
        w_dec  = !w_trig && bus.length_enable && bus.length_tick
              && (r_cnt != '0);
        w_next = r_state;
        if (!bus.dac_enable)
            w_next = S_IDLE;
        else if (bus.trigger)
            w_next = S_PLAYING;
        else if (r_state == S_PLAYING && w_dec && r_cnt == CNT_W'(1))
            w_next = S_IDLE;
        w_run = (r_state == S_PLAYING) && (w_next == S_PLAYING);
    end

    always_ff @(posedge frequency_timer_clock or posedge reset) begin
        if (reset) begin
            r_pos  <= '0;
            r_bank <= '0;
            r_cnt  <= '0;
            r_wave <= '0;
        end else begin
            r_wave <= w_run ? w_scaled : '0;
            if (w_trig) begin
                r_pos  <= '0;
                r_bank <= bus.bank_select;
                if (r_cnt == '0)
                    r_cnt <= w_reload;
            end else begin
                if (w_run) begin
                    r_pos <= r_pos + POS_W'(1);
                    if (r_pos == POS_W'(BANK_SAMPLES - 1) && bus.dimension)
                        r_bank <= r_bank + BANK_W'(1);
                end
                if (w_dec)
                    r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.wave_out     = r_wave;
    assign bus.active       = (r_state == S_PLAYING);
    assign bus.position     = r_pos;
    assign bus.bank_playing = r_bank;
endmodule
